// File: rtl/gyro_frame_bias.sv
// Gyro front-end: assembles the 14-byte MPU6050 burst, learns a per-axis zero-rate bias
// over 2^CAL_SHIFT frames, then emits bias-corrected, saturated rates with a one-cycle strobe.
module gyro_frame_bias #(
  parameter int CAL_SHIFT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  input  logic               frame_start,
  input  logic               recal,
  output logic signed [15:0] pitch_gyro,
  output logic signed [15:0] roll_gyro,
  output logic signed [15:0] yaw_gyro,
  output logic               cal_gyro_oe,
  output logic               cal_done,
  output logic               frame_drop
);

  localparam int ACC_W  = 16 + CAL_SHIFT;
  localparam int FCNT_W = CAL_SHIFT + 1;
  localparam logic [FCNT_W-1:0] FCNT_FULL = {1'b1, {CAL_SHIFT{1'b0}}};
  localparam logic [0:0] ST_CAL = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;

  // Framing state
  logic        active_q, active_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] raw_x_q, raw_x_d, raw_y_q, raw_y_d, raw_z_q, raw_z_d;
  logic        frame_done_q, frame_done_d;
  logic        drop_q, drop_d;

  // Calibration / run state
  logic [0:0]        state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [ACC_W-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d, acc_z_q, acc_z_d;
  logic              latch_q, latch_d;
  logic [15:0]       bias_x_q, bias_x_d, bias_y_q, bias_y_d, bias_z_q, bias_z_d;
  logic              cal_done_q, cal_done_d;

  // Output registers
  logic [15:0] pitch_q, pitch_d, roll_q, roll_d, yaw_q, yaw_d;
  logic        oe_q, oe_d;

  logic       take;
  logic [3:0] cur_idx;

  logic signed [ACC_W-1:0] avg_x, avg_y, avg_z;
  assign avg_x = $signed(acc_x_q) >>> CAL_SHIFT;
  assign avg_y = $signed(acc_y_q) >>> CAL_SHIFT;
  assign avg_z = $signed(acc_z_q) >>> CAL_SHIFT;

  function automatic logic [ACC_W-1:0] sext(input logic [15:0] v);
    return {{CAL_SHIFT{v[15]}}, v};
  endfunction

  // 17-bit difference; disagreeing top bits mean the result left the 16-bit range.
  function automatic logic [15:0] sat_sub(input logic [15:0] raw, input logic [15:0] bias);
    logic [16:0] diff;
    diff = {raw[15], raw} - {bias[15], bias};
    if (diff[16] != diff[15]) return diff[16] ? 16'h8000 : 16'h7FFF;
    return diff[15:0];
  endfunction

  always_comb begin
    active_d     = active_q;
    idx_d        = idx_q;
    raw_x_d      = raw_x_q;
    raw_y_d      = raw_y_q;
    raw_z_d      = raw_z_q;
    frame_done_d = 1'b0;
    drop_d       = 1'b0;
    take         = 1'b0;
    cur_idx      = idx_q;

    if (byte_valid) begin
      if (frame_start) begin
        drop_d  = active_q;
        cur_idx = 4'd0;
        take    = 1'b1;
      end else if (active_q) begin
        take = 1'b1;
      end
    end

    if (take) begin
      case (cur_idx)
        4'd8:    raw_x_d[15:8] = byte_in;
        4'd9:    raw_x_d[7:0]  = byte_in;
        4'd10:   raw_y_d[15:8] = byte_in;
        4'd11:   raw_y_d[7:0]  = byte_in;
        4'd12:   raw_z_d[15:8] = byte_in;
        4'd13:   raw_z_d[7:0]  = byte_in;
        default: ;
      endcase
      if (cur_idx == 4'd13) begin
        // Frame complete: stay idle until the next frame_start.
        active_d     = 1'b0;
        idx_d        = 4'd0;
        frame_done_d = ~recal;
      end else begin
        active_d = 1'b1;
        idx_d    = cur_idx + 4'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    acc_z_d    = acc_z_q;
    latch_d    = 1'b0;
    bias_x_d   = bias_x_q;
    bias_y_d   = bias_y_q;
    bias_z_d   = bias_z_q;
    cal_done_d = cal_done_q;
    pitch_d    = pitch_q;
    roll_d     = roll_q;
    yaw_d      = yaw_q;
    oe_d       = 1'b0;

    if (recal) begin
      state_d    = ST_CAL;
      fcnt_d     = '0;
      acc_x_d    = '0;
      acc_y_d    = '0;
      acc_z_d    = '0;
      bias_x_d   = '0;
      bias_y_d   = '0;
      bias_z_d   = '0;
      cal_done_d = 1'b0;
    end else begin
      if (latch_q) begin
        bias_x_d   = avg_x[15:0];
        bias_y_d   = avg_y[15:0];
        bias_z_d   = avg_z[15:0];
        cal_done_d = 1'b1;
        state_d    = ST_RUN;
      end
      if (frame_done_q) begin
        if (state_q == ST_CAL && !latch_q) begin
          acc_x_d = acc_x_q + sext(raw_x_q);
          acc_y_d = acc_y_q + sext(raw_y_q);
          acc_z_d = acc_z_q + sext(raw_z_q);
          fcnt_d  = fcnt_q + 1'b1;
          latch_d = (fcnt_d == FCNT_FULL);
        end else if (state_q == ST_RUN) begin
          pitch_d = sat_sub(raw_x_q, bias_x_q);
          roll_d  = sat_sub(raw_y_q, bias_y_q);
          yaw_d   = sat_sub(raw_z_q, bias_z_q);
          oe_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q     <= 1'b0;
      idx_q        <= '0;
      raw_x_q      <= '0;
      raw_y_q      <= '0;
      raw_z_q      <= '0;
      frame_done_q <= 1'b0;
      drop_q       <= 1'b0;
      state_q      <= ST_CAL;
      fcnt_q       <= '0;
      acc_x_q      <= '0;
      acc_y_q      <= '0;
      acc_z_q      <= '0;
      latch_q      <= 1'b0;
      bias_x_q     <= '0;
      bias_y_q     <= '0;
      bias_z_q     <= '0;
      cal_done_q   <= 1'b0;
      pitch_q      <= '0;
      roll_q       <= '0;
      yaw_q        <= '0;
      oe_q         <= 1'b0;
    end else begin
      active_q     <= active_d;
      idx_q        <= idx_d;
      raw_x_q      <= raw_x_d;
      raw_y_q      <= raw_y_d;
      raw_z_q      <= raw_z_d;
      frame_done_q <= frame_done_d;
      drop_q       <= drop_d;
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      acc_x_q      <= acc_x_d;
      acc_y_q      <= acc_y_d;
      acc_z_q      <= acc_z_d;
      latch_q      <= latch_d;
      bias_x_q     <= bias_x_d;
      bias_y_q     <= bias_y_d;
      bias_z_q     <= bias_z_d;
      cal_done_q   <= cal_done_d;
      pitch_q      <= pitch_d;
      roll_q       <= roll_d;
      yaw_q        <= yaw_d;
      oe_q         <= oe_d;
    end
  end

  assign pitch_gyro  = pitch_q;
  assign roll_gyro   = roll_q;
  assign yaw_gyro    = yaw_q;
  assign cal_gyro_oe = oe_q;
  assign cal_done    = cal_done_q;
  assign frame_drop  = drop_q;

endmodule

// File: tb/tb_gyro_frame_bias.sv
// Directed bench for gyro_frame_bias with CAL_SHIFT=2: vector table for RUN outputs,
// hand-written sequences for calibration timing, partial frames, saturation and recal.
module tb_gyro_frame_bias;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [7:0]         byte_in;
  logic               byte_valid;
  logic               frame_start;
  logic               recal;
  logic signed [15:0] pitch_gyro, roll_gyro, yaw_gyro;
  logic               cal_gyro_oe, cal_done, frame_drop;

  int n_checks = 0;
  int n_fail   = 0;
  int oe_count = 0;
  int drop_count = 0;

  gyro_frame_bias #(.CAL_SHIFT(2)) dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .frame_start(frame_start), .recal(recal), .pitch_gyro(pitch_gyro),
    .roll_gyro(roll_gyro), .yaw_gyro(yaw_gyro), .cal_gyro_oe(cal_gyro_oe),
    .cal_done(cal_done), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cal_gyro_oe) oe_count++;
    if (frame_drop) drop_count++;
  end

  typedef struct {
    logic signed [15:0] x, y, z;
    int ep, er, ey;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fs, input logic rc);
    byte_in = b; byte_valid = 1'b1; frame_start = fs; recal = rc;
    @(posedge clk); #1;
    byte_valid = 1'b0; frame_start = 1'b0; recal = 1'b0;
  endtask

  // Bytes 0..n-1 of a burst; recal rides on byte 13 when requested.
  task automatic send_bytes(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                            input int n, input logic rc);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      case (i)
        8:  b = x[15:8];
        9:  b = x[7:0];
        10: b = y[15:8];
        11: b = y[7:0];
        12: b = z[15:8];
        13: b = z[7:0];
        default: b = 8'hA0 + 8'(i);
      endcase
      send_byte(b, i == 0, rc && (i == 13));
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic cal_frame(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    send_bytes(x, y, z, 14, 1'b0);
    settle();
  endtask

  // Last calibration frame: cal_done must rise exactly 2 clocks after byte 13.
  task automatic last_cal_frame(input string name, input logic [15:0] x,
                                input logic [15:0] y, input logic [15:0] z);
    send_bytes(x, y, z, 14, 1'b0);
    @(negedge clk); chk({name, " cal_done k"}, int'(cal_done), 0);
    @(negedge clk); chk({name, " cal_done k+1"}, int'(cal_done), 0);
    @(negedge clk); chk({name, " cal_done k+2"}, int'(cal_done), 1);
    #1;
  endtask

  task automatic run_check(input string name, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] z, input int ep, input int er, input int ey);
    send_bytes(x, y, z, 14, 1'b0);
    @(negedge clk); chk({name, " oe at k"}, int'(cal_gyro_oe), 0);
    @(negedge clk);
    chk({name, " oe at k+1"}, int'(cal_gyro_oe), 1);
    chk({name, " pitch"}, int'(pitch_gyro), ep);
    chk({name, " roll"}, int'(roll_gyro), er);
    chk({name, " yaw"}, int'(yaw_gyro), ey);
    @(negedge clk); chk({name, " oe at k+2"}, int'(cal_gyro_oe), 0);
    #1;
  endtask

  int oe0, drop0;

  initial begin
    vecs[0] = '{x: 16'sd400,    y: -16'sd5,     z: 16'sd0,     ep: 299,    er: 0,      ey: 5};
    vecs[1] = '{x: 16'sd101,    y: -16'sd5,     z: -16'sd5,    ep: 0,      er: 0,      ey: 0};
    vecs[2] = '{x: -16'sd32768, y: 16'sd0,      z: 16'sd32767, ep: -32768, er: 5,      ey: 32767};
    vecs[3] = '{x: 16'sd32767,  y: -16'sd32768, z: 16'sd100,   ep: 32666,  er: -32763, ey: 105};
    vecs[4] = '{x: -16'sd1,     y: 16'sd10,     z: -16'sd10,   ep: -102,   er: 15,     ey: -5};

    rst_n = 1'b0; byte_in = '0; byte_valid = 1'b0; frame_start = 1'b0; recal = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset pitch", int'(pitch_gyro), 0);
    chk("reset oe", int'(cal_gyro_oe), 0);
    chk("reset cal_done", int'(cal_done), 0);
    chk("reset frame_drop", int'(frame_drop), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Unsynced: bytes without frame_start are ignored.
    for (int i = 0; i < 14; i++) send_byte(8'h55, 1'b0, 1'b0);
    settle();
    chk("unsynced pitch", int'(pitch_gyro), 0);
    chk("unsynced roll", int'(roll_gyro), 0);
    chk("unsynced yaw", int'(yaw_gyro), 0);
    chk("unsynced cal_done", int'(cal_done), 0);
    chk("unsynced oe count", oe_count, 0);

    // Calibration: X 100..103 -> bias 101, Y/Z -> -5.
    cal_frame(16'd100, -16'sd5, -16'sd5);
    cal_frame(16'd101, -16'sd5, -16'sd5);
    cal_frame(16'd102, -16'sd5, -16'sd5);
    chk("cal 3 frames cal_done", int'(cal_done), 0);
    last_cal_frame("cal avg", 16'd103, -16'sd5, -16'sd5);
    chk("cal no oe", oe_count, 0);

    for (int i = 0; i < 5; i++)
      run_check($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].z,
                vecs[i].ep, vecs[i].er, vecs[i].ey);

    // Bytes after a completed frame without frame_start are ignored.
    oe0 = oe_count;
    for (int i = 0; i < 14; i++) send_byte(8'h11, 1'b0, 1'b0);
    settle();
    chk("post-frame ignore oe", oe_count - oe0, 0);

    // Partial frame: frame_start arrives at byte position 9.
    oe0 = oe_count; drop0 = drop_count;
    send_bytes(16'd0, 16'd0, 16'd0, 9, 1'b0);
    run_check("after drop", 16'd200, -16'sd5, -16'sd5, 99, 0, 0);
    chk("drop pulse cycles", drop_count - drop0, 1);
    chk("drop single oe", oe_count - oe0, 1);

    // Recal on the byte-13 cycle: frame discarded, outputs hold.
    oe0 = oe_count;
    send_bytes(16'd1000, 16'd7, 16'd7, 14, 1'b1);
    settle();
    chk("recal no oe", oe_count - oe0, 0);
    chk("recal cal_done", int'(cal_done), 0);
    chk("recal hold pitch", int'(pitch_gyro), 99);
    chk("recal hold roll", int'(roll_gyro), 0);
    for (int i = 0; i < 3; i++) cal_frame(-16'sd100, 16'd0, 16'd0);
    chk("recal 3 frames cal_done", int'(cal_done), 0);
    last_cal_frame("recal", -16'sd100, 16'd0, 16'd0);
    run_check("sat pos", 16'sd32760, 16'd0, 16'd0, 32767, 0, 0);

    // Standalone recal, then bias +100 for negative saturation.
    recal = 1'b1; @(posedge clk); #1; recal = 1'b0;
    @(negedge clk);
    chk("recal2 cal_done", int'(cal_done), 0);
    chk("recal2 hold pitch", int'(pitch_gyro), 32767);
    for (int i = 0; i < 3; i++) cal_frame(16'd100, 16'd0, 16'd0);
    last_cal_frame("recal2", 16'd100, 16'd0, 16'd0);
    run_check("sat neg", -16'sd32768, 16'd0, 16'd0, -32768, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gyro_frame_bias.md
# gyro_frame_bias

Gyro front-end stage between the MPU6050 I2C burst reader and the gyro integrator. Assembles the 14-byte sensor burst (registers 0x3B..0x48) into signed words, learns a per-axis zero-rate bias by averaging 2^CAL_SHIFT frames after reset or on request, then emits bias-corrected, saturated pitch/roll/yaw rates. Each corrected frame is accompanied by a one-cycle `cal_gyro_oe` strobe that drives the integrator's sample enable.

## Interface
- `CAL_SHIFT`, default 8: log2 of the calibration frame count (256 frames). Legal range 1..12.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `byte_in` in 8: burst data byte from the I2C reader.
- `byte_valid` in 1: `byte_in` is valid this cycle.
- `frame_start` in 1: qualified by `byte_valid`; marks the current byte as byte 0 of a burst.
- `recal` in 1: single-cycle request to discard the bias and recalibrate.
- `pitch_gyro` out 16 signed: corrected gyro X.
- `roll_gyro` out 16 signed: corrected gyro Y.
- `yaw_gyro` out 16 signed: corrected gyro Z.
- `cal_gyro_oe` out 1: one-cycle strobe; the outputs carry a new sample.
- `cal_done` out 1: bias valid, block in RUN.
- `frame_drop` out 1: one-cycle pulse; a partial frame was discarded.

## Operation
- **Framing**
  - After reset the block is unsynced and ignores bytes until the first `byte_valid && frame_start`.
  - The byte counter runs 0..13. `frame_start` with `byte_valid` always forces the current byte to index 0.
  - Bytes are big-endian. Gyro X uses bytes 8/9, gyro Y bytes 10/11, gyro Z bytes 12/13. Bytes 0..7 (accel, temp) are counted but not stored.
  - The frame completes when byte 13 is accepted. Further bytes are ignored until the next `frame_start`.
  - If `frame_start` arrives while the counter is at 1..13 (incomplete frame), the old frame is discarded, `frame_drop` pulses for 1 cycle, and the new byte is taken as byte 0.
- **State CAL (reset state)**
  - On each completed frame, add the raw X/Y/Z words, sign-extended, into three accumulators of 16+CAL_SHIFT bits. Increment the frame counter.
  - When the counter reaches 2^CAL_SHIFT: bias = accumulator >>> CAL_SHIFT (arithmetic shift, floor), `cal_done` <= 1, and the state moves to RUN.
  - No `cal_gyro_oe` is issued in CAL. The outputs hold their value, which is 0 after reset.
- **State RUN**
  - Per completed frame, per axis: compute diff = raw − bias in 17 bits.
  - Saturate: >32767 gives 32767; <−32768 gives −32768; otherwise diff[15:0]. Register the result and pulse `cal_gyro_oe`.
- **Recalibration**
  - `recal` (any state) clears the accumulators, frame counter, bias and `cal_done`, and enters CAL.
  - Outputs hold their last values. Framing state is untouched.
  - If `recal` coincides with a frame completion or the bias-latch cycle, `recal` wins: that frame is neither accumulated nor output.
- **Reset**
  - Reset mid-frame or mid-calibration returns to the reset state immediately (asynchronous).

## Timing
- Reset values: `pitch_gyro`/`roll_gyro`/`yaw_gyro` = 0; `cal_gyro_oe` = 0; `cal_done` = 0; `frame_drop` = 0. State CAL, unsynced, all counters and accumulators 0.
- **Pipeline.** Byte 13 is accepted at edge k, and the raw words are registered at edge k.
  - RUN: outputs and `cal_gyro_oe` = 1 are registered at edge k+1. Latency is 1 clock from the last-byte edge.
  - CAL: accumulation happens at edge k+1. For the final calibration frame, bias and `cal_done` are registered at edge k+2.
  - A frame whose byte 13 is accepted at or after edge k+2 is output normally.
- Back-to-back bytes every cycle are supported. The minimum frame spacing is 14 cycles, and the pipeline never stalls.
- `cal_gyro_oe` is high for exactly 1 cycle per RUN frame and never in CAL.

## Test plan
Use CAL_SHIFT=2 unless noted.
- **Reset/unsynced.** Assert reset; send 14 bytes without `frame_start`. Required: all outputs 0, no `cal_gyro_oe`, `cal_done` 0.
- **Calibration average.** Send 4 frames with gyro X raw = 100, 101, 102, 103 and Y/Z = −5. Required: `cal_done` rises 2 clocks after the 4th byte 13. Bias X = 101 (406>>>2), bias Y/Z = −5. No `cal_gyro_oe` during calibration.
- **RUN output.** After the previous test, send one frame with X = 0x0190 (400), Y = 0xFFFB, Z = 0x0000. Required: 1 clock after byte 13, `cal_gyro_oe` pulses once with pitch 299, roll 0, yaw 5.
- **Saturation.** With bias X = −100 (calibrate on X = −100), send X = 32760. Required: pitch 32767. With bias X = +100, send X = −32768. Required: pitch −32768.
- **Partial frame.** Assert `frame_start` at byte 9. Required: `frame_drop` 1-cycle pulse, no `cal_gyro_oe` for the broken frame. The next full frame is output correctly.
- **Recal collision.** Pulse `recal` in the same cycle byte 13 is accepted in RUN. Required: no `cal_gyro_oe`, `cal_done` falls, outputs hold their last values, and recalibration needs 4 fresh frames.
